button_step_gen: RTL and testbench
==================================

// Module: button_step_gen
// PURPOSE
// Turns two raw pushbuttons (up/down) into clean single-cycle inc/dec step pulses with hold-to-repeat.
// Sits between the board buttons and the step counter, which consumes inc/dec pulses.
// Per-button flow: 2-flop synchronizer, then integrating debouncer, then a shared press/repeat FSM.
// inc and dec are mutually exclusive and never asserted for more than one consecutive cycle.
// PARAMETERS
// DEBOUNCE_CYCLES  240000   synced input must differ from debounced state this many consecutive cycles to flip it (>=2)
// REPEAT_DELAY     6000000  cycles from first pulse to first auto-repeat pulse (>=2)
// REPEAT_PERIOD    1200000  cycles between subsequent auto-repeat pulses (>=2)
// TIMER_W          24       width of debounce/repeat timers; must hold max(param)-1
// BTN_ACTIVE_LOW   1        1: raw button low = pressed; 0: high = pressed
// PORTS
// clk          in   1  system clock
// reset        in   1  synchronous, active-high reset
// btn_inc_raw  in   1  asynchronous raw "up" button
// btn_dec_raw  in   1  asynchronous raw "down" button
// repeat_en    in   1  1: hold-to-repeat enabled; 0: one pulse per press
// inc          out  1  one-cycle step-up pulse
// dec          out  1  one-cycle step-down pulse
// pressed      out  2  debounced levels {dec,inc}, 1 = pressed
// BEHAVIOUR
// - Reset, sampled on clk rising edge:
//   - outputs: inc=0, dec=0, pressed=2'b00
//   - sync flops load the released level; debounce/repeat timers clear; FSM enters IDLE
// - Polarity: raw is normalised to pressed=1 before the synchronizer.
// - Debounce, per button: cnt increments each cycle sync!=deb and clears when sync==deb.
//   When cnt==DEBOUNCE_CYCLES-1 and sync!=deb: deb<=sync, cnt<=0.
// - Latency: raw edge stable => pressed changes 2+DEBOUNCE_CYCLES cycles later; inc/dec pulse 1 cycle after that.
// - Glitches shorter than DEBOUNCE_CYCLES cycles never change pressed.
// - FSM states: IDLE, HOLD_INC, HOLD_DEC, LOCKOUT. Rise = deb 0->1 this cycle.
//   - IDLE, inc rise and dec not pressed: pulse inc, load timer=REPEAT_DELAY-1, go HOLD_INC. dec mirrors, to HOLD_DEC.
//   - IDLE, both pressed (incl. simultaneous rise): no pulse, go LOCKOUT.
//   - HOLD_INC, other button pressed: no pulse, go LOCKOUT (takes priority over repeat).
//   - HOLD_INC, own button released: go IDLE, no pulse.
//   - HOLD_INC, repeat_en=1: timer decrements each cycle; at 0, pulse and reload REPEAT_PERIOD-1.
//   - HOLD_INC, repeat_en=0: timer frozen, no pulses. repeat_en rising mid-hold resumes from the frozen value.
//   - HOLD_DEC mirrors HOLD_INC.
//   - LOCKOUT: no pulses; go IDLE only when both released (pressed==0).
//   - A fresh press from IDLE requires a release first; leaving HOLD_x to IDLE while the other button is held yields no pulse.
// - inc/dec are registered FSM outputs. Repeat pulse spacing is exactly REPEAT_PERIOD cycles.
// - Reset mid-hold: state discarded. A button still held debounces again after reset and yields a fresh first pulse.
// TESTING
// Use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, BTN_ACTIVE_LOW=1.
// 1. reset=1 two cycles, raws high -> inc=dec=0, pressed=00. Drive btn_inc_raw low at cycle 0 and hold
//    -> pressed[0]=1 at cycle 6, single inc pulse at cycle 7.
// 2. 3-cycle low glitch on btn_dec_raw -> pressed stays 00, no dec pulse.
// 3. repeat_en=1, hold inc 40 cycles -> inc pulses at 7, 17, 20, 23, ...; release -> no further pulses, FSM IDLE.
// 4. Both raws low same cycle -> no pulses; release one -> still none; release both, press dec -> exactly one dec pulse.
// 5. Holding inc in HOLD_INC, press dec -> no dec pulse, inc repeats stop; repeat_en=0 hold 40 cycles -> exactly one pulse.
// 6. Assert reset 1 cycle while inc is held mid-repeat -> outputs 0 next cycle; inc pulse again 7 cycles after reset release.

Source files
------------

// File: rtl/button_step_gen.sv
// button_step_gen: converts two raw pushbuttons (up/down) into clean,
// mutually exclusive single-cycle inc/dec step pulses with hold-to-repeat.
// Each button passes through a 2-flop synchronizer and an integrating
// debouncer. A shared press/repeat FSM then turns the debounced levels into
// registered pulses.
module button_step_gen #(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int REPEAT_DELAY    = 6000000,
  parameter int REPEAT_PERIOD   = 1200000,
  parameter int TIMER_W         = 24,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_inc_raw,
  input  logic       btn_dec_raw,
  input  logic       repeat_en,
  output logic       inc,
  output logic       dec,
  output logic [1:0] pressed
);

  localparam logic [TIMER_W-1:0] DB_LAST     = TIMER_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DELAY_LOAD  = TIMER_W'(REPEAT_DELAY - 1);
  localparam logic [TIMER_W-1:0] PERIOD_LOAD = TIMER_W'(REPEAT_PERIOD - 1);
  localparam logic [TIMER_W-1:0] T_ONE       = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] T_ZERO      = '0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD_INC = 2'd1,
    HOLD_DEC = 2'd2,
    LOCKOUT  = 2'd3
  } state_t;

  // Bit 0 is the inc button, bit 1 is the dec button throughout.
  logic [1:0]         w_raw_pressed;
  logic [1:0]         r_sync1;
  logic [1:0]         r_sync2;
  logic [1:0]         r_deb;
  logic [1:0]         r_deb_q;
  logic [TIMER_W-1:0] r_db_cnt [2];
  logic [1:0]         w_rise;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [TIMER_W-1:0] r_timer;
  logic [TIMER_W-1:0] w_timer_nxt;
  logic               r_inc;
  logic               r_dec;
  logic               w_inc_nxt;
  logic               w_dec_nxt;

  // Normalise polarity so that 1 always means "pressed" from here on.
  assign w_raw_pressed = BTN_ACTIVE_LOW ? ~{btn_dec_raw, btn_inc_raw}
                                        :  {btn_dec_raw, btn_inc_raw};

  // Two-flop synchronizer; reset loads the released level.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
    end else begin
      r_sync1 <= w_raw_pressed;
      r_sync2 <= r_sync1;
    end
  end

  // Integrating debouncer: the synced level must disagree with the debounced
  // level for DEBOUNCE_CYCLES consecutive cycles before the debounced level flips.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_deb       <= 2'b00;
      r_deb_q     <= 2'b00;
      r_db_cnt[0] <= T_ZERO;
      r_db_cnt[1] <= T_ZERO;
    end else begin
      r_deb_q <= r_deb;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_db_cnt[i] <= T_ZERO;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_deb[i]    <= r_sync2[i];
          r_db_cnt[i] <= T_ZERO;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + T_ONE;
        end
      end
    end
  end

  // A rise is a debounced 0->1 transition seen this cycle.
  assign w_rise = r_deb & ~r_deb_q;

  // FSM next-state, repeat timer and pulse decode. The other button being held
  // always wins over repeats; a new pulse from IDLE needs a genuine rise.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_inc_nxt   = 1'b0;
    w_dec_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (&r_deb) begin
          w_state_nxt = LOCKOUT;
        end else if (w_rise[0] && !r_deb[1]) begin
          w_inc_nxt   = 1'b1;
          w_timer_nxt = DELAY_LOAD;
          w_state_nxt = HOLD_INC;
        end else if (w_rise[1] && !r_deb[0]) begin
          w_dec_nxt   = 1'b1;
          w_timer_nxt = DELAY_LOAD;
          w_state_nxt = HOLD_DEC;
        end
      end
      HOLD_INC: begin
        if (r_deb[1]) begin
          w_state_nxt = LOCKOUT;
        end else if (!r_deb[0]) begin
          w_state_nxt = IDLE;
        end else if (repeat_en) begin
          if (r_timer == T_ZERO) begin
            w_inc_nxt   = 1'b1;
            w_timer_nxt = PERIOD_LOAD;
          end else begin
            w_timer_nxt = r_timer - T_ONE;
          end
        end
      end
      HOLD_DEC: begin
        if (r_deb[0]) begin
          w_state_nxt = LOCKOUT;
        end else if (!r_deb[1]) begin
          w_state_nxt = IDLE;
        end else if (repeat_en) begin
          if (r_timer == T_ZERO) begin
            w_dec_nxt   = 1'b1;
            w_timer_nxt = PERIOD_LOAD;
          end else begin
            w_timer_nxt = r_timer - T_ONE;
          end
        end
      end
      LOCKOUT: begin
        if (r_deb == 2'b00) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // FSM state, repeat timer and registered pulse outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_timer <= T_ZERO;
      r_inc   <= 1'b0;
      r_dec   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_inc   <= w_inc_nxt;
      r_dec   <= w_dec_nxt;
    end
  end

  assign inc     = r_inc;
  assign dec     = r_dec;
  assign pressed = r_deb;

endmodule

// File: tb/tb_button_step_gen.sv
// Directed testbench for button_step_gen with short debounce/repeat timing.
// Cycle n of a scenario means "sampled on the falling edge after the n-th
// rising edge following the stimulus change".
module tb_button_step_gen;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_inc_raw;
  logic       btn_dec_raw;
  logic       repeat_en;
  logic       inc;
  logic       dec;
  logic [1:0] pressed;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  button_step_gen #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .TIMER_W        (8),
    .BTN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_inc_raw(btn_inc_raw),
    .btn_dec_raw(btn_dec_raw),
    .repeat_en  (repeat_en),
    .inc        (inc),
    .dec        (dec),
    .pressed    (pressed)
  );

  // Reset with both buttons released.
  task automatic test_reset();
    reset       = 1'b1;
    btn_inc_raw = 1'b1;
    btn_dec_raw = 1'b1;
    repeat_en   = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({inc, dec} !== 2'b00) begin
      bad++;
      $display("FAIL reset_pulses got=%b exp=00", {inc, dec});
    end
    total++;
    if (pressed !== 2'b00) begin
      bad++;
      $display("FAIL reset_pressed got=%b exp=00", pressed);
    end
    reset = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      total++;
      if ({pressed, inc, dec} !== 4'b0000) begin
        bad++;
        $display("FAIL idle_after_reset n=%0d got=%b exp=0000", n, {pressed, inc, dec});
      end
    end
  endtask

  // Single press: pressed at cycle 6, one inc pulse at cycle 7, then release.
  task automatic test_first_press();
    btn_inc_raw = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      total++;
      if (pressed !== {1'b0, (n >= 6)}) begin
        bad++;
        $display("FAIL press_level n=%0d got=%b exp=%b", n, pressed, {1'b0, (n >= 6)});
      end
      total++;
      if ({inc, dec} !== {(n == 7), 1'b0}) begin
        bad++;
        $display("FAIL press_pulse n=%0d got=%b exp=%b", n, {inc, dec}, {(n == 7), 1'b0});
      end
    end
    btn_inc_raw = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      total++;
      if (pressed !== {1'b0, (n < 6)}) begin
        bad++;
        $display("FAIL release_level n=%0d got=%b exp=%b", n, pressed, {1'b0, (n < 6)});
      end
      total++;
      if ({inc, dec} !== 2'b00) begin
        bad++;
        $display("FAIL release_pulse n=%0d got=%b exp=00", n, {inc, dec});
      end
    end
  endtask

  // A 3-cycle glitch on dec is one cycle short of flipping the debouncer.
  task automatic test_glitch();
    btn_dec_raw = 1'b0;
    repeat (3) @(negedge clk);
    btn_dec_raw = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      total++;
      if ({pressed, inc, dec} !== 4'b0000) begin
        bad++;
        $display("FAIL glitch n=%0d got=%b exp=0000", n, {pressed, inc, dec});
      end
    end
  endtask

  // Hold inc for 40 cycles with repeat: pulses 7, 17, 20, 23 ... until the
  // debounced release lands at cycle 46.
  task automatic test_repeat();
    logic exp_inc;
    repeat_en   = 1'b1;
    btn_inc_raw = 1'b0;
    for (int n = 1; n <= 52; n++) begin
      @(negedge clk);
      exp_inc = (n == 7) || (n >= 17 && n <= 46 && ((n - 17) % 3) == 0);
      total++;
      if ({inc, dec} !== {exp_inc, 1'b0}) begin
        bad++;
        $display("FAIL repeat n=%0d got=%b exp=%b", n, {inc, dec}, {exp_inc, 1'b0});
      end
      if (n == 40) btn_inc_raw = 1'b1;
    end
    total++;
    if (pressed !== 2'b00) begin
      bad++;
      $display("FAIL repeat_released got=%b exp=00", pressed);
    end
  endtask

  // Simultaneous press locks out; only a clean release plus fresh press pulses.
  task automatic test_lockout();
    btn_inc_raw = 1'b0;
    btn_dec_raw = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      total++;
      if ({pressed, inc, dec} !== {((n >= 6) ? 2'b11 : 2'b00), 2'b00}) begin
        bad++;
        $display("FAIL both_press n=%0d got=%b exp=%b", n, {pressed, inc, dec},
                 {((n >= 6) ? 2'b11 : 2'b00), 2'b00});
      end
    end
    btn_inc_raw = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      total++;
      if ({pressed, inc, dec} !== {((n >= 6) ? 2'b10 : 2'b11), 2'b00}) begin
        bad++;
        $display("FAIL release_one n=%0d got=%b exp=%b", n, {pressed, inc, dec},
                 {((n >= 6) ? 2'b10 : 2'b11), 2'b00});
      end
    end
    btn_dec_raw = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      total++;
      if ({pressed, inc, dec} !== {((n >= 6) ? 2'b00 : 2'b10), 2'b00}) begin
        bad++;
        $display("FAIL release_both n=%0d got=%b exp=%b", n, {pressed, inc, dec},
                 {((n >= 6) ? 2'b00 : 2'b10), 2'b00});
      end
    end
    btn_dec_raw = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      total++;
      if ({inc, dec} !== {1'b0, (n == 7)}) begin
        bad++;
        $display("FAIL dec_after_lockout n=%0d got=%b exp=%b", n, {inc, dec}, {1'b0, (n == 7)});
      end
    end
    btn_dec_raw = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      total++;
      if ({inc, dec} !== 2'b00) begin
        bad++;
        $display("FAIL dec_release n=%0d got=%b exp=00", n, {inc, dec});
      end
    end
  endtask

  // Pressing dec while inc is held kills repeats; repeat_en=0 gives one pulse.
  task automatic test_cross_and_norepeat();
    repeat_en   = 1'b1;
    btn_inc_raw = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      total++;
      if ({inc, dec} !== {(n == 7), 1'b0}) begin
        bad++;
        $display("FAIL cross_press n=%0d got=%b exp=%b", n, {inc, dec}, {(n == 7), 1'b0});
      end
      if (n == 9) btn_dec_raw = 1'b0;
    end
    btn_inc_raw = 1'b1;
    btn_dec_raw = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      total++;
      if ({inc, dec} !== 2'b00) begin
        bad++;
        $display("FAIL cross_release n=%0d got=%b exp=00", n, {inc, dec});
      end
    end
    repeat_en   = 1'b0;
    btn_inc_raw = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      total++;
      if ({inc, dec} !== {(n == 7), 1'b0}) begin
        bad++;
        $display("FAIL norepeat n=%0d got=%b exp=%b", n, {inc, dec}, {(n == 7), 1'b0});
      end
    end
    btn_inc_raw = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      total++;
      if ({inc, dec} !== 2'b00) begin
        bad++;
        $display("FAIL norepeat_release n=%0d got=%b exp=00", n, {inc, dec});
      end
    end
    total++;
    if (pressed !== 2'b00) begin
      bad++;
      $display("FAIL norepeat_released got=%b exp=00", pressed);
    end
  endtask

  // One-cycle reset while inc repeats; held button gives a fresh pulse 7 later.
  task automatic test_reset_mid_hold();
    logic exp_inc;
    repeat_en   = 1'b1;
    btn_inc_raw = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      exp_inc = (n == 7) || (n == 17) || (n == 20);
      total++;
      if ({inc, dec} !== {exp_inc, 1'b0}) begin
        bad++;
        $display("FAIL pre_reset n=%0d got=%b exp=%b", n, {inc, dec}, {exp_inc, 1'b0});
      end
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if ({pressed, inc, dec} !== 4'b0000) begin
      bad++;
      $display("FAIL mid_reset got=%b exp=0000", {pressed, inc, dec});
    end
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      total++;
      if ({pressed, inc, dec} !== {1'b0, (n >= 6), (n == 7), 1'b0}) begin
        bad++;
        $display("FAIL after_reset n=%0d got=%b exp=%b", n, {pressed, inc, dec},
                 {1'b0, (n >= 6), (n == 7), 1'b0});
      end
    end
    btn_inc_raw = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_first_press();
    test_glitch();
    test_repeat();
    test_lockout();
    test_cross_and_norepeat();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
